// File: rtl/servo_pkg.sv
// Register map, write clamp and parameter range checks for the servo PWM array.
package servo_pkg;

  localparam logic [3:0] ADDR_PULSE0 = 4'd0;
  localparam logic [3:0] ADDR_CAP0   = 4'd4;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;
  localparam int         MAX_CH      = 4;

  // Zero means "no pulse"; anything else is forced into [lo, hi].
  function automatic logic [31:0] pulse_clamp(input logic [31:0] value,
                                               input logic [31:0] lo,
                                               input logic [31:0] hi);
    logic [31:0] res;
    if (value == '0)     res = '0;
    else if (value < lo) res = lo;
    else if (value > hi) res = hi;
    else                 res = value;
    return res;
  endfunction

  function automatic bit num_ch_ok(input int n);
    return (n >= 1) && (n <= MAX_CH);
  endfunction

  function automatic bit timing_ok(input int period, input int pmin, input int pmax);
    return (period >= 2) && (pmin <= pmax) && (pmax < period);
  endfunction

endpackage

// File: rtl/servo_fb_capture.sv
// Feedback pulse measurement: 2-flop synchroniser, edge detect and a saturating
// high-time counter; strobes once per completed pulse.
module servo_fb_capture #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fb,
  output logic [CNT_W-1:0] cap_value,
  output logic             cap_strobe
);

  logic             sync0_reg;
  logic             sync1_reg;
  logic             sync1_d_reg;
  logic             meas_reg;
  logic [CNT_W-1:0] high_cnt_reg;
  logic             rise;
  logic             fall;

  assign rise = sync1_reg & ~sync1_d_reg;
  assign fall = ~sync1_reg & sync1_d_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Reset high so a pulse already in progress at release shows no rising edge.
      sync0_reg    <= 1'b1;
      sync1_reg    <= 1'b1;
      sync1_d_reg  <= 1'b1;
      meas_reg     <= 1'b0;
      high_cnt_reg <= '0;
    end else begin
      sync0_reg   <= fb;
      sync1_reg   <= sync0_reg;
      sync1_d_reg <= sync1_reg;
      if (rise) begin
        meas_reg     <= 1'b1;
        high_cnt_reg <= CNT_W'(1);
      end else if (sync1_reg && (high_cnt_reg != '1)) begin
        high_cnt_reg <= high_cnt_reg + CNT_W'(1);
      end
      if (fall) begin
        meas_reg <= 1'b0;
      end
    end
  end

  assign cap_value  = high_cnt_reg;
  assign cap_strobe = fall & meas_reg;

endmodule

// File: rtl/servo_pwm_array_avalon.sv
// Multi-channel servo PWM with period-boundary updates, pulse clamping and
// feedback pulse capture behind an Avalon-MM slave.
module servo_pwm_array_avalon
  import servo_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int CNT_W     = 32,
  parameter int PERIOD    = 1000000,
  parameter int PULSE_MIN = 50000,
  parameter int PULSE_MAX = 100000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [NUM_CH-1:0] pwm_fb,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic              wr_en;
  logic              rd_en;
  logic              wrap;
  logic              ctrl_wr;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  wr_pulse;
  logic [NUM_CH-1:0] ctrl_reg;
  logic [NUM_CH-1:0] en_active_reg;
  logic [NUM_CH-1:0] status_reg;
  logic [NUM_CH-1:0] status_next;
  logic [NUM_CH-1:0] pulse_wr;
  logic [NUM_CH-1:0] cap_strobe;
  logic [CNT_W-1:0]  active    [NUM_CH];
  logic [CNT_W-1:0]  capture   [NUM_CH];
  logic [CNT_W-1:0]  cap_value [NUM_CH];
  logic [31:0]       rd_mux;

  param_check: assert property (@(posedge clk)
    num_ch_ok(NUM_CH) && timing_ok(PERIOD, PULSE_MIN, PULSE_MAX));

  assign wr_en    = chipselect & write;
  assign rd_en    = chipselect & read;
  assign wrap     = (cnt_reg == CNT_LAST);
  assign ctrl_wr  = wr_en && (address == ADDR_CTRL);
  assign wr_pulse = CNT_W'(pulse_clamp(writedata, 32'(PULSE_MIN), 32'(PULSE_MAX)));

  // A capture landing with a W1C on the same cycle keeps its status bit set.
  always_comb begin
    status_next = status_reg;
    if (wr_en && (address == ADDR_STATUS)) begin
      status_next = status_reg & ~writedata[NUM_CH-1:0];
    end
    status_next = status_next | cap_strobe;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (address == ADDR_PULSE0 + 4'(i)) rd_mux = 32'(active[i]);
      if (address == ADDR_CAP0 + 4'(i))   rd_mux = 32'(capture[i]);
    end
    if (address == ADDR_CTRL)   rd_mux = 32'(ctrl_reg);
    if (address == ADDR_STATUS) rd_mux = 32'(status_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg       <= '0;
      ctrl_reg      <= '0;
      en_active_reg <= '0;
      status_reg    <= '0;
      readdata      <= '0;
    end else begin
      cnt_reg <= wrap ? '0 : cnt_reg + CNT_W'(1);
      if (ctrl_wr) begin
        ctrl_reg <= writedata[NUM_CH-1:0];
      end
      if (wrap) begin
        en_active_reg <= ctrl_wr ? writedata[NUM_CH-1:0] : ctrl_reg;
      end
      status_reg <= status_next;
      if (rd_en) begin
        readdata <= rd_mux;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] shadow_reg;
    logic [CNT_W-1:0] active_reg;
    logic [CNT_W-1:0] capture_reg;
    logic             pwm_reg;

    assign pulse_wr[gi] = wr_en && (address == ADDR_PULSE0 + 4'(gi));

    servo_fb_capture #(
      .CNT_W(CNT_W)
    ) u_fb_capture (
      .clk       (clk),
      .reset_n   (reset_n),
      .fb        (pwm_fb[gi]),
      .cap_value (cap_value[gi]),
      .cap_strobe(cap_strobe[gi])
    );

    // A write on the wrap cycle bypasses the shadow straight into the new period.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shadow_reg  <= '0;
        active_reg  <= '0;
        capture_reg <= '0;
        pwm_reg     <= 1'b0;
      end else begin
        if (pulse_wr[gi]) begin
          shadow_reg <= wr_pulse;
        end
        if (wrap) begin
          active_reg <= pulse_wr[gi] ? wr_pulse : shadow_reg;
        end
        if (cap_strobe[gi]) begin
          capture_reg <= cap_value[gi];
        end
        pwm_reg <= en_active_reg[gi] && (cnt_reg < active_reg);
      end
    end

    assign active[gi]  = active_reg;
    assign capture[gi] = capture_reg;
    assign pwm_out[gi] = pwm_reg;
  end

endmodule

// File: tb/tb_servo_pwm_array_avalon.sv
// Self-checking bench: register vectors, period-level PWM pattern model and
// feedback capture sequences for the servo PWM array.
module tb_servo_pwm_array_avalon;

  localparam int NCH  = 3;
  localparam int PER  = 20;
  localparam int PMIN = 2;
  localparam int PMAX = 10;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [3:0]      address = '0;
  logic            chipselect = 1'b0;
  logic            read = 1'b0;
  logic            write = 1'b0;
  logic [31:0]     writedata = '0;
  logic [31:0]     readdata;
  logic [NCH-1:0]  pwm_fb = '0;
  logic [NCH-1:0]  pwm_out;

  always #5 clk = ~clk;

  servo_pwm_array_avalon #(
    .NUM_CH   (NCH),
    .CNT_W    (32),
    .PERIOD   (PER),
    .PULSE_MIN(PMIN),
    .PULSE_MAX(PMAX)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .pwm_fb    (pwm_fb),
    .pwm_out   (pwm_out)
  );

  int total = 0;
  int bad   = 0;

  // Position within the PWM period, counted from reset release.
  int tb_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cnt <= 0;
    else          tb_cnt <= (tb_cnt == PER - 1) ? 0 : tb_cnt + 1;
  end

  // Per-period picture of each output: bit c = pwm_out seen while the period sits at c.
  logic [PER-1:0] cur_mask  [NCH];
  logic [PER-1:0] done_mask [NCH];
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) cur_mask[i][tb_cnt] = pwm_out[i];
    if (tb_cnt == PER - 1) begin
      for (int i = 0; i < NCH; i++) done_mask[i] = cur_mask[i];
    end
  end

  // Reference model state
  int unsigned    m_sh  [NCH];
  int unsigned    m_act [NCH];
  logic [NCH-1:0] m_ctrl;
  logic [NCH-1:0] m_en;

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input bit w, input logic [3:0] a, input logic [31:0] d,
                              input logic [31:0] e);
    vec_t v;
    v.is_wr = w;
    v.addr  = a;
    v.data  = d;
    v.exp   = e;
    return v;
  endfunction

  function automatic int unsigned ref_clamp(input int unsigned d);
    if (d == 0)    return 0;
    if (d < PMIN)  return PMIN;
    if (d > PMAX)  return PMAX;
    return d;
  endfunction

  function automatic logic [PER-1:0] exp_mask(input int unsigned w, input logic en);
    logic [PER-1:0] m;
    m = '0;
    if (en) for (int c = 1; c <= int'(w); c++) m[c] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tb_cnt != v && k < 3 * PER);
    if (tb_cnt != v) begin
      total++;
      bad++;
      $display("FAIL wait_cnt: got %0d expected %0d", tb_cnt, v);
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write      = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
    if (a < NCH) m_sh[a] = ref_clamp(d);
    if (a == 4'd8) m_ctrl = d[NCH-1:0];
    $display("wr addr=%0d data=%0h", a, d);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    read       = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    d = readdata;
    $display("rd addr=%0d data=%0h", a, d);
  endtask

  task automatic apply_boundary();
    for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
    m_en = m_ctrl;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh[i]  = 0;
      m_act[i] = 0;
    end
    m_ctrl = '0;
    m_en   = '0;
  endtask

  task automatic check_masks(input string tag);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("%s mask ch%0d", tag, i), 32'(done_mask[i]), 32'(exp_mask(m_act[i], m_en[i])));
  endtask

  // Start of the next period: new values active; read them back, then check the waveform.
  task automatic check_next_period(input string tag);
    logic [31:0] rd;
    wait_cnt(0);
    apply_boundary();
    for (int i = 0; i < NCH; i++) begin
      bus_read(4'(i), rd);
      chk($sformatf("%s pulse%0d", tag, i), rd, m_act[i]);
    end
    wait_cnt(PER - 1);
    @(negedge clk);
    check_masks(tag);
  endtask

  task automatic run_vecs(input int lo, input int hi, input string tag);
    logic [31:0] rd;
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].is_wr) begin
        reg_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd);
        chk($sformatf("%s v%0d addr%0d", tag, i, vecs[i].addr), rd, vecs[i].exp);
      end
    end
  endtask

  task automatic fb_pulse(input int ch, input int w);
    @(negedge clk);
    pwm_fb[ch] = 1'b1;
    repeat (w) @(negedge clk);
    pwm_fb[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          ch;
    int          w;
    int          kind;

    // Reset-state table: every mapped and one unmapped address read 0.
    for (int i = 0; i < 10; i++) vecs[i] = mk(1'b0, 4'(i), 32'd0, 32'd0);
    vecs[10] = mk(1'b0, 4'd15, 32'd0, 32'd0);
    // Decode table: holes, unmapped and read-only writes leave state intact.
    vecs[11] = mk(1'b0, 4'd3,  32'd0, 32'd0);
    vecs[12] = mk(1'b0, 4'd7,  32'd0, 32'd0);
    vecs[13] = mk(1'b0, 4'd12, 32'd0, 32'd0);
    vecs[14] = mk(1'b1, 4'd12, 32'hFFFF_FFFF, 32'd0);
    vecs[15] = mk(1'b1, 4'd4,  32'h0000_0055, 32'd0);
    vecs[16] = mk(1'b1, 4'd3,  32'd9, 32'd0);
    vecs[17] = mk(1'b0, 4'd12, 32'd0, 32'd0);
    vecs[18] = mk(1'b0, 4'd4,  32'd0, 32'd4);
    vecs[19] = mk(1'b0, 4'd3,  32'd0, 32'd0);
    vecs[20] = mk(1'b0, 4'd1,  32'd0, 32'd6);
    vecs[21] = mk(1'b0, 4'd13, 32'd0, 32'd0);
    vecs[22] = mk(1'b0, 4'd9,  32'd0, 32'd1);
    vecs[23] = mk(1'b0, 4'd8,  32'd0, 32'd7);

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset pwm_out", 32'(pwm_out), 32'd0);
    chk("reset readdata", readdata, 32'd0);
    reset_n = 1'b1;
    run_vecs(0, 10, "reset");

    // 1: programme three channels; nothing moves until the wrap
    wait_cnt(0);
    reg_write(4'd8, 32'd7);
    reg_write(4'd0, 32'd3);
    reg_write(4'd1, 32'd5);
    reg_write(4'd2, 32'd4);
    bus_read(4'd0, rd);
    chk("t1 pulse0 before wrap", rd, 32'd0);
    wait_cnt(PER - 1);
    @(negedge clk);
    check_masks("t1 before wrap");
    check_next_period("t1");

    // 2: clamping of large, small and zero widths
    reg_write(4'd0, 32'd15);
    check_next_period("t2 clamp hi");
    reg_write(4'd0, 32'd1);
    check_next_period("t2 clamp lo");
    reg_write(4'd0, 32'd0);
    check_next_period("t2 zero");

    // 3: mid-period write, then a write on the wrap cycle itself
    wait_cnt(2);
    reg_write(4'd1, 32'd8);
    wait_cnt(PER - 1);
    @(negedge clk);
    check_masks("t3 current");
    apply_boundary();
    wait_cnt(PER - 1);
    @(negedge clk);
    check_masks("t3 next");
    wait_cnt(PER - 2);
    reg_write(4'd1, 32'd6);
    check_masks("t3 before wrapwrite");
    apply_boundary();
    wait_cnt(PER - 1);
    @(negedge clk);
    check_masks("t3 wrapwrite");

    // 4: capture, W1C, then W1C colliding with a fresh capture
    fb_pulse(0, 7);
    repeat (5) @(negedge clk);
    bus_read(4'd4, rd);
    chk("t4 capture0", rd, 32'd7);
    bus_read(4'd9, rd);
    chk("t4 status", rd, 32'd1);
    reg_write(4'd9, 32'd1);
    bus_read(4'd9, rd);
    chk("t4 status cleared", rd, 32'd0);
    fb_pulse(0, 4);
    @(negedge clk);
    reg_write(4'd9, 32'd1);
    bus_read(4'd9, rd);
    chk("t4 status w1c collide", rd, 32'd1);
    bus_read(4'd4, rd);
    chk("t4 capture0 second", rd, 32'd4);

    // 5: decode holes and readdata hold
    run_vecs(11, 23, "t5");
    repeat (3) @(negedge clk);
    chk("t5 readdata hold", readdata, 32'd7);

    // Randomized PWM programming against the period model
    for (int it = 0; it < 5; it++) begin
      reg_write(4'd8, $urandom);
      for (int i = 0; i < NCH; i++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0:       reg_write(4'(i), 32'd0);
          1:       reg_write(4'(i), $urandom_range(1, 12));
          2:       reg_write(4'(i), $urandom);
          default: reg_write(4'(i), $urandom_range(PMIN, PMAX));
        endcase
      end
      check_next_period($sformatf("rand%0d", it));
    end

    // Randomized feedback captures on all channels
    for (int it = 0; it < 4; it++) begin
      reg_write(4'd9, 32'd7);
      ch = $urandom_range(0, NCH - 1);
      w  = $urandom_range(1, 25);
      fb_pulse(ch, w);
      repeat (5) @(negedge clk);
      bus_read(4'(4 + ch), rd);
      chk($sformatf("rcap%0d ch%0d", it, ch), rd, 32'(w));
      bus_read(4'd9, rd);
      chk($sformatf("rcap%0d status", it), rd, 32'(1 << ch));
    end

    // 6: reset in the middle of a pulse, with a feedback pulse spanning release
    reg_write(4'd8, 32'd7);
    for (int i = 0; i < NCH; i++) reg_write(4'(i), 32'd5);
    bus_read(4'd8, rd);
    chk("t6 ctrl before reset", rd, 32'd7);
    wait_cnt(0);
    wait_cnt(3);
    chk("t6 pwm high before reset", 32'(pwm_out), 32'd7);
    pwm_fb[2] = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("t6 pwm async low", 32'(pwm_out), 32'd0);
    chk("t6 readdata async", readdata, 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    pwm_fb[2] = 1'b0;
    repeat (6) @(negedge clk);
    run_vecs(0, 10, "t6 after reset");
    wait_cnt(PER - 1);
    @(negedge clk);
    check_masks("t6 idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
